// File: rtl/mat_vect_fcmp_pipe.sv
// mat_vect_fcmp_pipe: pipelined floating-point comparator with the HLS fcmp
// opcode set, signed-zero handling, negative-operand ordering and a valid
// pipeline. Latency is NUM_STAGE ce-qualified clocks.
// Optional feature macro: FCMP_NAN_CHECK_EN. When it is defined, NaN decode
// and the UNO opcode are built. When it is undefined, NaN is ordered as a
// large magnitude and UNO reports op_err.
module mat_vect_fcmp_pipe #(
   parameter int ID         = 27,
   parameter int NUM_STAGE  = 2,
   parameter int din0_WIDTH = 32,
   parameter int din1_WIDTH = 32,
   parameter int EXP_WIDTH  = 8,
   parameter int dout_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ce,
   input  logic                  din_vld,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic [4:0]            opcode,
   output logic                  dout,
   output logic                  dout_vld,
   output logic                  op_err
);

   localparam int W         = din0_WIDTH;
   localparam int MAN_WIDTH = W - 1 - EXP_WIDTH;
   // Result registers after the compare: one when decode+compare share the
   // only stage, otherwise stage 2 onward.
   localparam int RES_STAGES = (NUM_STAGE < 2) ? 1 : NUM_STAGE - 1;

   localparam logic [4:0] OP_OEQ = 5'b00001;
   localparam logic [4:0] OP_OGT = 5'b00010;
   localparam logic [4:0] OP_OGE = 5'b00011;
   localparam logic [4:0] OP_OLT = 5'b00100;
   localparam logic [4:0] OP_OLE = 5'b00101;
   localparam logic [4:0] OP_ONE = 5'b00110;
`ifdef FCMP_NAN_CHECK_EN
   localparam logic [4:0] OP_UNO = 5'b01000;
`endif

   // ---------------------------------------------------------------
   // Field decode (combinational on the raw operands)
   // ---------------------------------------------------------------
   logic         dec_sign0, dec_sign1, dec_zero0, dec_zero1;
   logic [W-2:0] dec_mag0, dec_mag1;

   assign dec_sign0 = din0[W-1];
   assign dec_sign1 = din1[W-1];
   assign dec_mag0  = din0[W-2:0];
   assign dec_mag1  = din1[W-2:0];
   assign dec_zero0 = (dec_mag0 == '0);
   assign dec_zero1 = (dec_mag1 == '0);

`ifdef FCMP_NAN_CHECK_EN
   logic dec_nan0, dec_nan1;
   assign dec_nan0 = (&din0[W-2:MAN_WIDTH]) & (|din0[MAN_WIDTH-1:0]);
   assign dec_nan1 = (&din1[W-2:MAN_WIDTH]) & (|din1[MAN_WIDTH-1:0]);
`endif

   // ---------------------------------------------------------------
   // Compare inputs: either the decode directly or the stage-1 registers
   // ---------------------------------------------------------------
   logic         cmp_vld, cmp_sign0, cmp_sign1, cmp_zero0, cmp_zero1;
   logic [W-2:0] cmp_mag0, cmp_mag1;
   logic [4:0]   cmp_op;
`ifdef FCMP_NAN_CHECK_EN
   logic         cmp_nan0, cmp_nan1;
`endif

   generate
      if (NUM_STAGE < 2) begin : g_s1_bypass
         assign cmp_vld   = din_vld;
         assign cmp_sign0 = dec_sign0;
         assign cmp_sign1 = dec_sign1;
         assign cmp_zero0 = dec_zero0;
         assign cmp_zero1 = dec_zero1;
         assign cmp_mag0  = dec_mag0;
         assign cmp_mag1  = dec_mag1;
         assign cmp_op    = opcode;
`ifdef FCMP_NAN_CHECK_EN
         assign cmp_nan0  = dec_nan0;
         assign cmp_nan1  = dec_nan1;
`endif
      end else begin : g_s1_reg
         logic         s1_vld_reg, s1_sign0_reg, s1_sign1_reg, s1_zero0_reg, s1_zero1_reg;
         logic [W-2:0] s1_mag0_reg, s1_mag1_reg;
         logic [4:0]   s1_op_reg;
`ifdef FCMP_NAN_CHECK_EN
         logic         s1_nan0_reg, s1_nan1_reg;
`endif
         // Stage 1: capture decoded fields while ce is high
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               s1_vld_reg   <= 1'b0;
               s1_sign0_reg <= 1'b0;
               s1_sign1_reg <= 1'b0;
               s1_zero0_reg <= 1'b0;
               s1_zero1_reg <= 1'b0;
               s1_mag0_reg  <= '0;
               s1_mag1_reg  <= '0;
               s1_op_reg    <= '0;
`ifdef FCMP_NAN_CHECK_EN
               s1_nan0_reg  <= 1'b0;
               s1_nan1_reg  <= 1'b0;
`endif
            end else if (ce) begin
               s1_vld_reg   <= din_vld;
               s1_sign0_reg <= dec_sign0;
               s1_sign1_reg <= dec_sign1;
               s1_zero0_reg <= dec_zero0;
               s1_zero1_reg <= dec_zero1;
               s1_mag0_reg  <= dec_mag0;
               s1_mag1_reg  <= dec_mag1;
               s1_op_reg    <= opcode;
`ifdef FCMP_NAN_CHECK_EN
               s1_nan0_reg  <= dec_nan0;
               s1_nan1_reg  <= dec_nan1;
`endif
            end
         end
         assign cmp_vld   = s1_vld_reg;
         assign cmp_sign0 = s1_sign0_reg;
         assign cmp_sign1 = s1_sign1_reg;
         assign cmp_zero0 = s1_zero0_reg;
         assign cmp_zero1 = s1_zero1_reg;
         assign cmp_mag0  = s1_mag0_reg;
         assign cmp_mag1  = s1_mag1_reg;
         assign cmp_op    = s1_op_reg;
`ifdef FCMP_NAN_CHECK_EN
         assign cmp_nan0  = s1_nan0_reg;
         assign cmp_nan1  = s1_nan1_reg;
`endif
      end
   endgenerate

   // ---------------------------------------------------------------
   // Ordering and opcode evaluation
   // ---------------------------------------------------------------
   logic cmp_eq, cmp_lt, cmp_ord, cmp_res, cmp_err;

`ifdef FCMP_NAN_CHECK_EN
   assign cmp_ord = ~(cmp_nan0 | cmp_nan1);
`else
   assign cmp_ord = 1'b1;
`endif

   // Sign/magnitude ordering; +0 and -0 are equal and neither is less
   always_comb begin
      cmp_eq = ((cmp_sign0 == cmp_sign1) && (cmp_mag0 == cmp_mag1)) || (cmp_zero0 && cmp_zero1);
      if (cmp_zero0 && cmp_zero1)
         cmp_lt = 1'b0;
      else if (cmp_sign0 != cmp_sign1)
         cmp_lt = cmp_sign0;
      else if (!cmp_sign0)
         cmp_lt = (cmp_mag0 < cmp_mag1);
      else
         cmp_lt = (cmp_mag0 > cmp_mag1);
   end

   // Opcode select; unsupported codes give dout=0 with op_err set
   always_comb begin
      cmp_res = 1'b0;
      cmp_err = 1'b0;
      case (cmp_op)
         OP_OEQ:  cmp_res = cmp_ord & cmp_eq;
         OP_OGT:  cmp_res = cmp_ord & ~cmp_lt & ~cmp_eq;
         OP_OGE:  cmp_res = cmp_ord & ~cmp_lt;
         OP_OLT:  cmp_res = cmp_ord & cmp_lt;
         OP_OLE:  cmp_res = cmp_ord & (cmp_lt | cmp_eq);
         OP_ONE:  cmp_res = cmp_ord & ~cmp_eq;
`ifdef FCMP_NAN_CHECK_EN
         OP_UNO:  cmp_res = ~cmp_ord;
`endif
         default: cmp_err = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------
   // Result pipeline; the last stage keeps dout/op_err across bubbles
   // ---------------------------------------------------------------
   logic rs_vld_reg [RES_STAGES];
   logic rs_res_reg [RES_STAGES];
   logic rs_err_reg [RES_STAGES];

   genvar gi;
   generate
      for (gi = 0; gi < RES_STAGES; gi++) begin : g_res
         logic in_vld, in_res, in_err;
         if (gi == 0) begin : g_src
            assign in_vld = cmp_vld;
            assign in_res = cmp_res;
            assign in_err = cmp_err;
         end else begin : g_src
            assign in_vld = rs_vld_reg[gi-1];
            assign in_res = rs_res_reg[gi-1];
            assign in_err = rs_err_reg[gi-1];
         end

         // Advance one result stage per ce; output stage holds data on bubbles
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               rs_vld_reg[gi] <= 1'b0;
               rs_res_reg[gi] <= 1'b0;
               rs_err_reg[gi] <= 1'b0;
            end else if (ce) begin
               rs_vld_reg[gi] <= in_vld;
               if (in_vld || (gi != RES_STAGES - 1)) begin
                  rs_res_reg[gi] <= in_res;
                  rs_err_reg[gi] <= in_err;
               end
            end
         end
      end
   endgenerate

   assign dout     = rs_res_reg[RES_STAGES-1];
   assign dout_vld = rs_vld_reg[RES_STAGES-1];
   assign op_err   = rs_err_reg[RES_STAGES-1];

endmodule

// File: tb/tb_mat_vect_fcmp_pipe.sv
// Directed bench for mat_vect_fcmp_pipe: a 32-bit float instance and a
// 64-bit double instance, both NUM_STAGE=2, sharing clock, reset and ce.
`timescale 1ns/1ps
module tb_mat_vect_fcmp_pipe;

   localparam logic [4:0] OEQ = 5'd1;
   localparam logic [4:0] OGT = 5'd2;
   localparam logic [4:0] OGE = 5'd3;
   localparam logic [4:0] OLT = 5'd4;
   localparam logic [4:0] OLE = 5'd5;
   localparam logic [4:0] ONE = 5'd6;
   localparam logic [4:0] BAD = 5'd7;
   localparam logic [4:0] UNO = 5'd8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce = 1'b1;

   logic        vld32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic [4:0]  op32 = '0;
   logic        dout32, dvld32, err32;

   logic        vld64 = 1'b0;
   logic [63:0] a64 = '0, b64 = '0;
   logic [4:0]  op64 = '0;
   logic        dout64, dvld64, err64;

   int n_checks = 0;
   int n_fail   = 0;

   // Stream vectors and per-cycle expected output (index = negedge number)
   logic [31:0] s_a  [8] = '{32'h3F800000, 32'h40000000, 32'hC0000000, 32'h3F800000,
                             32'h3F800000, 32'h40400000, 32'hBF800000, 32'h80000000};
   logic [31:0] s_b  [8] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40000000,
                             32'h40000000, 32'h40000000, 32'hBF800000, 32'h00000000};
   logic [4:0]  s_op [8] = '{OLT, OLT, OLT, OEQ, OGT, OGE, ONE, OLE};
   logic        x_vld  [14] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
   logic        x_dout [14] = '{0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 1, 0, 1, 1};

   mat_vect_fcmp_pipe #(.NUM_STAGE(2), .din0_WIDTH(32), .din1_WIDTH(32), .EXP_WIDTH(8)) u_dut32 (
      .clk(clk), .reset_n(reset_n), .ce(ce), .din_vld(vld32), .din0(a32), .din1(b32),
      .opcode(op32), .dout(dout32), .dout_vld(dvld32), .op_err(err32));

   mat_vect_fcmp_pipe #(.NUM_STAGE(2), .din0_WIDTH(64), .din1_WIDTH(64), .EXP_WIDTH(11)) u_dut64 (
      .clk(clk), .reset_n(reset_n), .ce(ce), .din_vld(vld64), .din0(a64), .din1(b64),
      .opcode(op64), .dout(dout64), .dout_vld(dvld64), .op_err(err64));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One isolated compare: drive, confirm nothing after one cycle, check after two
   task automatic run_cmp(input bit wide, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] op, input logic exp_d, input logic exp_e,
                          input string tag);
      @(negedge clk);
      if (wide) begin
         a64 = a; b64 = b; op64 = op; vld64 = 1'b1;
      end else begin
         a32 = a[31:0]; b32 = b[31:0]; op32 = op; vld32 = 1'b1;
      end
      @(negedge clk);
      vld32 = 1'b0;
      vld64 = 1'b0;
      check({tag, "/vld_at_1"}, wide ? dvld64 : dvld32, 64'd0);
      @(negedge clk);
      check({tag, "/vld"},  wide ? dvld64 : dvld32, 64'd1);
      check({tag, "/dout"}, wide ? dout64 : dout32, {63'd0, exp_d});
      check({tag, "/err"},  wide ? err64  : err32,  {63'd0, exp_e});
      $display("txn %s: a=%0h b=%0h op=%0d dout=%0b op_err=%0b", tag, a, b, op,
               wide ? dout64 : dout32, wide ? err64 : err32);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst/dout32", dout32, 64'd0);
      check("rst/vld32",  dvld32, 64'd0);
      check("rst/err32",  err32,  64'd0);
      check("rst/vld64",  dvld64, 64'd0);
      reset_n = 1'b1;

      // Negative ordering and signed zero
      run_cmp(0, 32'hBF800000, 32'hC0000000, OLT, 1'b0, 1'b0, "olt_m1_m2");
      run_cmp(0, 32'hC0000000, 32'hBF800000, OLT, 1'b1, 1'b0, "olt_m2_m1");
      run_cmp(0, 32'h00000000, 32'h80000000, OEQ, 1'b1, 1'b0, "oeq_pz_nz");
      run_cmp(0, 32'h00000000, 32'h80000000, OLT, 1'b0, 1'b0, "olt_pz_nz");
      run_cmp(0, 32'h40000000, 32'h3F800000, OGT, 1'b1, 1'b0, "ogt_2_1");
      run_cmp(0, 32'h3F800000, 32'h3F800000, OLE, 1'b1, 1'b0, "ole_1_1");
      run_cmp(0, 32'h3F800000, 32'hBF800000, ONE, 1'b1, 1'b0, "one_1_m1");
      run_cmp(0, 32'h80000000, 32'h3F800000, OGE, 1'b0, 1'b0, "oge_nz_1");

      // NaN handling
`ifdef FCMP_NAN_CHECK_EN
      run_cmp(0, 32'h7FC00000, 32'h3F800000, OLT, 1'b0, 1'b0, "nan_olt");
      run_cmp(0, 32'h7FC00000, 32'h3F800000, OGE, 1'b0, 1'b0, "nan_oge");
      run_cmp(0, 32'h7FC00000, 32'h3F800000, OEQ, 1'b0, 1'b0, "nan_oeq");
      run_cmp(0, 32'h7FC00000, 32'h3F800000, ONE, 1'b0, 1'b0, "nan_one");
      run_cmp(0, 32'h7FC00000, 32'h3F800000, UNO, 1'b1, 1'b0, "nan_uno");
      run_cmp(0, 32'h3F800000, 32'h40000000, UNO, 1'b0, 1'b0, "uno_ordered");
`else
      run_cmp(0, 32'h7FC00000, 32'h3F800000, UNO, 1'b0, 1'b1, "nan_uno_off");
      run_cmp(0, 32'h7FC00000, 32'h3F800000, OGE, 1'b1, 1'b0, "nan_oge_off");
`endif

      // Unsupported opcodes
      run_cmp(0, 32'h3F800000, 32'h40000000, BAD,      1'b0, 1'b1, "op_00111");
      run_cmp(0, 32'h3F800000, 32'h40000000, 5'b00000, 1'b0, 1'b1, "op_00000");
      run_cmp(0, 32'h3F800000, 32'h40000000, 5'b11111, 1'b0, 1'b1, "op_11111");

      // Back-to-back stream with a 3-cycle ce stall
      for (int n = 0; n < 14; n++) begin
         @(negedge clk);
         if (n >= 1) begin
            check($sformatf("stream/vld_n%0d", n), dvld32, {63'd0, x_vld[n]});
            if (n >= 2)
               check($sformatf("stream/dout_n%0d", n), dout32, {63'd0, x_dout[n]});
            $display("txn stream n=%0d: ce=%0b dout_vld=%0b dout=%0b", n, ce, dvld32, dout32);
         end
         ce = (n >= 4 && n <= 6) ? 1'b0 : 1'b1;
         if (n < 4) begin
            a32 = s_a[n]; b32 = s_b[n]; op32 = s_op[n]; vld32 = 1'b1;
         end else if (n <= 6) begin
            a32 = s_a[4]; b32 = s_b[4]; op32 = s_op[4]; vld32 = 1'b1;
         end else if (n <= 10) begin
            a32 = s_a[n-3]; b32 = s_b[n-3]; op32 = s_op[n-3]; vld32 = 1'b1;
         end else begin
            vld32 = 1'b0;
         end
      end
      ce = 1'b1;
      vld32 = 1'b0;

      // Reset with two samples in flight
      @(negedge clk);
      a32 = 32'h3F800000; b32 = 32'h40000000; op32 = OLT; vld32 = 1'b1;
      @(negedge clk);
      a32 = 32'hC0000000; b32 = 32'h3F800000; op32 = OLT; vld32 = 1'b1;
      @(negedge clk);
      vld32 = 1'b0;
      check("flush/pre_vld",  dvld32, 64'd1);
      check("flush/pre_dout", dout32, 64'd1);
      #2 reset_n = 1'b0;
      #1;
      check("flush/dout", dout32, 64'd0);
      check("flush/vld",  dvld32, 64'd0);
      check("flush/err",  err32,  64'd0);
      $display("txn flush: dout=%0b dout_vld=%0b op_err=%0b", dout32, dvld32, err32);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("flush/post_vld_%0d", k), dvld32, 64'd0);
      end

      // Double-precision instance
      run_cmp(1, 64'hBFF0000000000000, 64'hC000000000000000, OLT, 1'b0, 1'b0, "d_olt_m1_m2");
      run_cmp(1, 64'hC000000000000000, 64'hBFF0000000000000, OLT, 1'b1, 1'b0, "d_olt_m2_m1");
      run_cmp(1, 64'h0000000000000000, 64'h8000000000000000, OEQ, 1'b1, 1'b0, "d_oeq_pz_nz");
      run_cmp(1, 64'h0000000000000000, 64'h8000000000000000, OLT, 1'b0, 1'b0, "d_olt_pz_nz");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
